// File: rtl/brm_sync_pkg.sv
// Shared types and constants for the backup-RAM dirty-block sync engine.
// Holds the FSM state encoding, block geometry and the stream header format.
package brm_sync_pkg;

    localparam int unsigned AddrW     = 18;
    localparam int unsigned DataW     = 16;
    localparam int unsigned BLK_WORDS = 2048;
    localparam int unsigned WcntW     = $clog2(BLK_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StHdr,
        StRd,
        StWt,
        StPush,
        StDone
    } state_e;

    // Header word: block index in the low bits, upper bits reserved as zero.
    function automatic logic [DataW-1:0] hdr_word(input logic [DataW-1:0] blk_zext);
        return blk_zext;
    endfunction

endpackage

// File: rtl/brm_sync_if.sv
// Engine-side bus bundle: backup-RAM read port plus the outbound word stream.
// The engine drives the master modport; memory and stream sink sit on the slave side.
interface brm_sync_if;

    logic [brm_sync_pkg::AddrW-1:0] rd_addr;
    logic                           rd_oe;
    logic [brm_sync_pkg::DataW-1:0] rd_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [brm_sync_pkg::DataW-1:0] out_data;
    logic                           out_hdr;

    modport master (
        output rd_addr,
        output rd_oe,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_hdr
    );

    modport slave (
        input  rd_addr,
        input  rd_oe,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_hdr
    );

endinterface

// File: rtl/brm_dirty_map.sv
// Per-block dirty bitmap fed by cartridge-side write snooping.
// A snoop set and an engine clear landing on the same block in one cycle leave the bit set.
module brm_dirty_map #(
    parameter int unsigned BLK_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_i,
    input  logic [BLK_W-1:0] set_idx_i,
    input  logic             clr_i,
    input  logic [BLK_W-1:0] idx_i,
    output logic             tst_o,
    output logic             dirty_any_o
);

    localparam int unsigned NumBlk = 1 << BLK_W;

    logic [NumBlk-1:0] dirty_q, dirty_d;
    logic [NumBlk-1:0] set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_i) set_mask[set_idx_i] = 1'b1;
        if (clr_i) clr_mask[idx_i] = 1'b1;
        dirty_d = (dirty_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q <= '0;
        end else begin
            dirty_q <= dirty_d;
        end
    end

    assign tst_o       = dirty_q[idx_i];
    assign dirty_any_o = |dirty_q;

endmodule

// File: rtl/brm_sync.sv
// Dirty-block sync engine: scans the dirty map and streams each dirty 4 KB block
// as one header word followed by its 2048 data words, one read in flight at a time.
module brm_sync
    import brm_sync_pkg::*;
#(
    parameter int unsigned BLK_W  = 6,
    parameter int unsigned RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AddrW-1:0] snoop_addr,
    input  logic             snoop_we_lo,
    input  logic             snoop_we_hi,
    input  logic             cpu_busy,
    input  logic             sync_req,
    brm_sync_if.master       bus,
    output logic             sync_busy,
    output logic             sync_done,
    output logic             dirty_any
);

    localparam int unsigned LatW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   ptr_q, ptr_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [WcntW-1:0]   wcnt_q, wcnt_d;
    logic [LatW-1:0]    lat_q, lat_d;
    logic [DataW-1:0]   word_q, word_d;
    logic               blk_dirty;
    logic               clr;

    brm_dirty_map #(
        .BLK_W(BLK_W)
    ) u_dirty_map (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (snoop_we_lo | snoop_we_hi),
        .set_idx_i  (snoop_addr[AddrW-1 -: BLK_W]),
        .clr_i      (clr),
        .idx_i      (ptr_q),
        .tst_o      (blk_dirty),
        .dirty_any_o(dirty_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            blk_q   <= '0;
            wcnt_q  <= '0;
            lat_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            blk_q   <= blk_d;
            wcnt_q  <= wcnt_d;
            lat_q   <= lat_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        blk_d         = blk_q;
        wcnt_d        = wcnt_q;
        lat_d         = lat_q;
        word_d        = word_q;
        clr           = 1'b0;
        bus.rd_oe     = 1'b0;
        bus.rd_addr   = '0;
        bus.out_valid = 1'b0;
        bus.out_hdr   = 1'b0;
        bus.out_data  = '0;

        unique case (state_q)
            StIdle: begin
                if (sync_req) begin
                    state_d = StScan;
                    ptr_d   = '0;
                end
            end
            StScan: begin
                if (blk_dirty) begin
                    blk_d   = ptr_q;
                    clr     = 1'b1;
                    state_d = StHdr;
                end else if (ptr_q == '1) begin
                    state_d = StDone;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StHdr: begin
                bus.out_valid = 1'b1;
                bus.out_hdr   = 1'b1;
                bus.out_data  = hdr_word(DataW'(blk_q));
                if (bus.out_ready) begin
                    wcnt_d  = '0;
                    state_d = StRd;
                end
            end
            StRd: begin
                // The cartridge side has priority on the shared port.
                if (!cpu_busy) begin
                    bus.rd_oe   = 1'b1;
                    bus.rd_addr = AddrW'({blk_q, wcnt_q, 1'b0});
                    lat_d       = '0;
                    state_d     = StWt;
                end
            end
            StWt: begin
                if (lat_q == LatW'(RD_LAT - 1)) begin
                    word_d  = bus.rd_data;
                    state_d = StPush;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StPush: begin
                bus.out_valid = 1'b1;
                bus.out_data  = word_q;
                if (bus.out_ready) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q != '1) begin
                        state_d = StRd;
                    end else if (blk_q == '1) begin
                        // Last block of the space: nothing left to scan.
                        state_d = StDone;
                    end else begin
                        ptr_d   = blk_q + 1'b1;
                        state_d = StScan;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign sync_busy = (state_q != StIdle);
    assign sync_done = (state_q == StDone);

endmodule

// File: tb/tb_brm_sync.sv
// Randomised self-checking bench for brm_sync against a block-level stream model.
// The model lists dirty blocks per pass and expands each into header + 2048 memory words.
module tb_brm_sync;
    import brm_sync_pkg::*;

    localparam int unsigned RdLat = 2;
    localparam int unsigned NBlk  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] snoop_addr = '0;
    logic        snoop_we_lo = 1'b0;
    logic        snoop_we_hi = 1'b0;
    logic        cpu_busy = 1'b0;
    logic        sync_req = 1'b0;
    logic        sync_busy, sync_done, dirty_any;

    brm_sync_if bus ();

    brm_sync #(
        .BLK_W (6),
        .RD_LAT(RdLat)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .snoop_addr (snoop_addr),
        .snoop_we_lo(snoop_we_lo),
        .snoop_we_hi(snoop_we_hi),
        .cpu_busy   (cpu_busy),
        .sync_req   (sync_req),
        .bus        (bus),
        .sync_busy  (sync_busy),
        .sync_done  (sync_done),
        .dirty_any  (dirty_any)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    bit          model_dirty [NBlk];
    logic [16:0] exp_q[$];
    logic [17:0] exp_addr_q[$];
    logic [15:0] hdr_log[$];
    int          outstanding = 0;
    int          words_seen = 0;
    int          valid_cnt = 0;
    int          rd_cnt = 0;
    int          stall_checks = 0;
    int          done_cnt = 0;
    int          req_cyc = 0;
    int          done_cyc = 0;
    logic [17:0] first_addr = '0;
    logic [17:0] last_addr = '0;
    bit          prev_stall = 1'b0;
    logic [16:0] prev_word = '0;

    function automatic logic [15:0] mem_word(input logic [17:0] a);
        logic [31:0] t;
        t = {14'b0, a} * 32'd40503;
        return t[23:8] ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event occurred, expected none (cycle %0d)", name, cyc);
    endtask

    // Memory model: read data appears RdLat cycles after the strobe, garbage otherwise.
    logic [17:0] hist_addr [RdLat+1];
    logic        hist_oe   [RdLat+1];
    initial begin
        bus.rd_data = '0;
        for (int i = 0; i <= RdLat; i++) begin
            hist_oe[i]   = 1'b0;
            hist_addr[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = RdLat; i > 0; i--) begin
                hist_oe[i]   = hist_oe[i-1];
                hist_addr[i] = hist_addr[i-1];
            end
            hist_oe[0]   = bus.rd_oe;
            hist_addr[0] = bus.rd_addr;
            bus.rd_data  = hist_oe[RdLat] ? mem_word(hist_addr[RdLat]) : 16'($urandom);
        end
    end

    // Compare process: every negedge, check the DUT against the model queues.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("reset_outputs", {bus.rd_oe, bus.out_valid, bus.out_hdr, sync_busy,
                    sync_done, dirty_any, bus.rd_addr, bus.out_data}, 64'd0);
                outstanding = 0;
                prev_stall  = 1'b0;
            end else begin
                if (sync_req) req_cyc = cyc;
                if (bus.rd_oe) begin
                    chk("rd_oe_while_cpu_busy", {63'd0, cpu_busy}, 64'd0);
                    chk("one_read_outstanding", outstanding, 0);
                    outstanding++;
                    if (rd_cnt == 0) first_addr = bus.rd_addr;
                    last_addr = bus.rd_addr;
                    rd_cnt++;
                    if (exp_addr_q.size() == 0) bad("rd_oe_unexpected");
                    else chk("rd_addr", bus.rd_addr, exp_addr_q.pop_front());
                end
                if (prev_stall) begin
                    stall_checks++;
                    chk("stall_hold", {bus.out_valid, bus.out_hdr, bus.out_data},
                        {1'b1, prev_word});
                end
                if (bus.out_valid) valid_cnt++;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) bad("stream_word_unexpected");
                    else chk("stream_word", {bus.out_hdr, bus.out_data}, exp_q.pop_front());
                    if (bus.out_hdr) begin
                        hdr_log.push_back(bus.out_data);
                    end else begin
                        words_seen++;
                        outstanding--;
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_word  = {bus.out_hdr, bus.out_data};
                if (sync_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_with_stream_drained", exp_q.size(), 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snoop_wr(input logic [17:0] a, input logic [1:0] we);
        snoop_addr  = a;
        snoop_we_lo = we[0];
        snoop_we_hi = we[1];
        if (we != 2'b00) model_dirty[a[17:12]] = 1'b1;
        tick();
        snoop_we_lo = 1'b0;
        snoop_we_hi = 1'b0;
        snoop_addr  = 18'($urandom);
    endtask

    // Expected pass: every dirty block in ascending order, then the model clears it.
    task automatic start_pass();
        logic [17:0] a;
        words_seen = 0;
        valid_cnt  = 0;
        rd_cnt     = 0;
        hdr_log.delete();
        for (int b = 0; b < NBlk; b++) begin
            if (model_dirty[b]) begin
                exp_q.push_back({1'b1, 16'(b)});
                for (int w = 0; w < int'(BLK_WORDS); w++) begin
                    a = {6'(b), 11'(w), 1'b0};
                    exp_addr_q.push_back(a);
                    exp_q.push_back({1'b0, mem_word(a)});
                end
                model_dirty[b] = 1'b0;
            end
        end
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int rdy_pct, input int busy_pct,
                             input int wr_blk);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            cpu_busy      = ($urandom_range(99) < busy_pct);
            snoop_addr    = 18'($urandom);
            snoop_we_lo   = 1'b0;
            snoop_we_hi   = 1'b0;
            if (wr_blk >= 0 && words_seen >= 1 && words_seen < 2047 &&
                $urandom_range(31) == 0) begin
                snoop_addr = {6'(wr_blk), 12'($urandom)};
                {snoop_we_hi, snoop_we_lo} = 2'($urandom_range(3, 1));
                model_dirty[wr_blk] = 1'b1;
            end
            tick();
            n++;
        end
        snoop_we_lo   = 1'b0;
        snoop_we_hi   = 1'b0;
        bus.out_ready = 1'b1;
        cpu_busy      = 1'b0;
        chk("pass_finished_in_budget", {63'd0, done_cnt != start}, 64'd1);
    endtask

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rd_before;
        int d0;
        for (int b = 0; b < NBlk; b++) model_dirty[b] = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_reset_idle", {62'd0, sync_busy, dirty_any}, 64'd0);

        // Single block 1, full ready, with a 10-cycle cpu_busy window mid-block.
        snoop_wr(18'h01234, 2'b01);
        chk("dirty_any_after_write", {63'd0, dirty_any}, 64'd1);
        start_pass();
        n = 0;
        while (words_seen < 10 && n < 200) begin tick(); n++; end
        rd_before = rd_cnt;
        cpu_busy  = 1'b1;
        repeat (10) tick();
        cpu_busy  = 1'b0;
        chk("no_rd_oe_while_busy_window", rd_cnt - rd_before, 0);
        chk("busy_mid_pass", {63'd0, sync_busy}, 64'd1);
        wait_done(20000, 100, 0, -1);
        chk("blk1_header", hdr_log.size() > 0 ? hdr_log[0] : 16'hFFFF, 16'h0001);
        chk("blk1_word_count", words_seen, 2048);
        chk("blk1_first_addr", first_addr, 18'h01000);
        chk("blk1_last_addr", last_addr, 18'h01FFE);
        chk("blk1_dirty_cleared", {62'd0, dirty_any, sync_busy}, 64'd0);

        // Empty pass: pure scan of all 64 blocks.
        start_pass();
        wait_done(200, 100, 0, -1);
        chk("empty_done_latency", done_cyc - req_cyc, 65);
        chk("empty_no_out_valid", valid_cnt, 0);

        // Block 2: snoop write on the clear cycle, then writes while it streams.
        snoop_wr({6'd2, 12'h010}, 2'b10);
        start_pass();
        tick();
        tick();
        snoop_wr({6'd2, 12'h7FE}, 2'b01);
        tick();
        chk("set_wins_over_clear", {63'd0, dirty_any}, 64'd1);
        wait_done(20000, 90, 10, 2);
        chk("blk2_header", hdr_log.size() > 0 ? hdr_log[0] : 16'hFFFF, 16'h0002);
        chk("blk2_dirty_after_pass", {63'd0, dirty_any}, 64'd1);
        start_pass();
        wait_done(20000, 85, 15, -1);
        chk("blk2_resent", hdr_log.size() > 0 ? hdr_log[0] : 16'hFFFF, 16'h0002);
        chk("blk2_resend_clean", {63'd0, dirty_any}, 64'd0);

        // Blocks 0 and 63 with random backpressure and port contention.
        snoop_wr({6'd63, 12'($urandom)}, 2'($urandom_range(3, 1)));
        snoop_wr({6'd0, 12'($urandom)}, 2'($urandom_range(3, 1)));
        start_pass();
        wait_done(40000, 80, 20, -1);
        chk("two_blk_hdr_count", hdr_log.size(), 2);
        chk("two_blk_hdr0", hdr_log.size() > 0 ? hdr_log[0] : 16'hFFFF, 16'h0000);
        chk("two_blk_hdr1", hdr_log.size() > 1 ? hdr_log[1] : 16'hFFFF, 16'h003F);
        chk("two_blk_total_words", words_seen + hdr_log.size(), 4098);

        // Stall in PUSH for 5 cycles, then abort the pass with reset.
        snoop_wr({6'd5, 12'h100}, 2'b11);
        start_pass();
        n = 0;
        while (words_seen < 3 && n < 200) begin tick(); n++; end
        bus.out_ready = 1'b0;
        n = 0;
        while (!(bus.out_valid && !bus.out_hdr) && n < 20) begin tick(); n++; end
        d0 = stall_checks;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_cycles_checked", stall_checks - d0, 5);
        repeat (3) tick();
        snoop_wr({6'd9, 12'h000}, 2'b01);
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        for (int b = 0; b < NBlk; b++) model_dirty[b] = 1'b0;
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) tick();
        chk("abort_idle_clean", {62'd0, sync_busy, dirty_any}, 64'd0);
        chk("abort_no_done_pulse", done_cnt - d0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/brm_sync.md
BRM_SYNC -- requirements
Module: brm_sync

Interface
REQ-001 Parameter BLK_W, default 6, sets the dirty-block index width (64 blocks of 4 KB over the 256 KB backup-RAM space).
REQ-002 Parameter RD_LAT, default 2, sets the memory read latency in clk cycles from rd_oe to valid rd_data.
REQ-003 clk  in  1  system clock; the only clock domain.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 snoop_addr  in  18  byte address of the cartridge-side backup-RAM access.
REQ-006 snoop_we_lo / snoop_we_hi  in  1 each  cartridge-side byte write strobes.
REQ-007 cpu_busy  in  1  high while the cartridge side owns the backup-RAM port.
REQ-008 sync_req  in  1  single-cycle pulse from the MCU that starts a sync pass.
REQ-009 rd_addr  out  18  engine read byte address; bit 0 is always 0.
REQ-010 rd_oe  out  1  engine read strobe, one cycle per word.
REQ-011 rd_data  in  16  read data, valid RD_LAT cycles after rd_oe.
REQ-012 out_valid / out_ready  out / in  1 each  output stream handshake.
REQ-013 out_data  out  16  stream word.
REQ-014 out_hdr  out  1  high when out_data is a block header word.
REQ-015 sync_busy  out  1  high while a pass is in progress.
REQ-016 sync_done  out  1  one-cycle pulse when a pass ends.
REQ-017 dirty_any  out  1  OR of all dirty bits.

Function
REQ-018 Any cycle with snoop_we_lo or snoop_we_hi high shall set dirty[snoop_addr[17:12]] on the next clk edge.
REQ-019 The FSM shall use states IDLE, SCAN, HDR, RD, WT, PUSH and DONE.
REQ-020 IDLE: on sync_req, go to SCAN with scan pointer 0; sync_req shall be ignored in every other state.
REQ-021 SCAN: test one block per cycle; on a dirty block, latch it as blk, clear its dirty bit and go to HDR; after block 63 with none found, go to DONE.
REQ-022 HDR: present out_hdr=1 and out_data={10'b0, blk}; on out_valid&out_ready, go to RD with word counter 0.
REQ-023 RD: assert rd_oe for one cycle with rd_addr={blk, wcnt[10:0], 1'b0}, only when cpu_busy=0; otherwise hold in RD.
REQ-024 WT: wait RD_LAT cycles, capture rd_data, then go to PUSH.
REQ-025 PUSH: present out_valid with out_hdr=0 and the captured word; on out_ready, increment wcnt.
REQ-026 After PUSH, return to RD while wcnt<2047; after word 2047, return to SCAN at blk+1.
REQ-027 Only one read shall be outstanding; each block streams exactly 1 header and 2048 data words.
REQ-028 out_data and out_hdr shall stay stable while out_valid=1 and out_ready=0.
REQ-029 A snoop write to blk in the same cycle the engine clears it shall leave the bit set (set wins).
REQ-030 A write to a block after it is cleared shall re-set its bit; the current pass shall not revisit it, and the next pass shall.
REQ-031 DONE: pulse sync_done for one cycle, then go to IDLE.
REQ-032 sync_busy shall be high in every state except IDLE.

Reset
REQ-033 rst_n low shall asynchronously force state IDLE and clear all dirty bits, blk, wcnt and the scan pointer.
REQ-034 During reset, rd_oe, out_valid, out_hdr, sync_busy, sync_done and dirty_any shall be 0, and rd_addr and out_data shall be 0.
REQ-035 A reset asserted mid-pass shall abort the pass without a sync_done pulse.

Structure
REQ-036 Package brm_sync_pkg shall hold the state enum, BLK_WORDS=2048 and the header format.
REQ-037 Sub-module brm_dirty_map shall hold the dirty bitmap, the set/clear priority and dirty_any.

Verification
REQ-038 Reset, write to byte 0x01234 (block 1), pulse sync_req, out_ready=1 -> header 0x0001, then 2048 words with rd_addr 0x01000..0x01FFE, then sync_done, and dirty_any=0.
REQ-039 No writes, pulse sync_req -> no out_valid, and sync_done exactly 65 cycles after sync_req.
REQ-040 Write to blocks 0 and 63, then sync -> headers 0x0000 then 0x003F, 4098 stream words in total.
REQ-041 cpu_busy=1 for 10 cycles during RD -> rd_oe stays 0 for those cycles and no word is dropped or duplicated.
REQ-042 Snoop write to blk on the clear cycle, and a write to block 2 while block 2 streams -> dirty bit remains 1 after the pass, and the next pass resends the block.
REQ-043 out_ready held 0 for 5 cycles in PUSH, and rst_n pulsed low mid-block -> data is held stable while stalled; after reset the state is IDLE, dirty_any=0 and no sync_done pulse occurs.
